// File: rtl/mac_row_seq_pkg.sv
// Shared types for the MAC row sequencer: FSM state encoding and the
// 2-bit row instruction codes driven onto the row's west input.
package mac_row_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_row_seq_if.sv
// Bus bundle between the sequencer, its weight/activation sources and the
// MAC row west edge. master = sequencer side, slave = sources/row side.
interface mac_row_seq_if #(
  parameter int BW        = 4,
  parameter int INDEX_SEL = 2,
  parameter int COL       = 8
);
  localparam int DW = BW * INDEX_SEL;

  // valid/ready: a word moves on every rising clk edge where valid and ready
  // are both 1; ready never depends on valid, and valid/data must hold until
  // accepted.
  logic [DW-1:0]  w_data;
  logic           w_valid;
  logic           w_ready;
  logic [DW-1:0]  a_data;
  logic           a_valid;
  logic           a_ready;
  logic [DW-1:0]  row_in_w;
  logic [1:0]     row_inst_w;
  logic [COL-1:0] row_valid;

  modport master (
    input  w_data, w_valid,
    output w_ready,
    input  a_data, a_valid,
    output a_ready,
    output row_in_w, row_inst_w,
    input  row_valid
  );

  modport slave (
    output w_data, w_valid,
    input  w_ready,
    output a_data, a_valid,
    input  a_ready,
    input  row_in_w, row_inst_w,
    output row_valid
  );

endinterface

// File: rtl/mac_row_seq_beat_counter.sv
// Clearable up-counter with terminal compare; below_o gates ready, last_o
// flags that the next increment reaches the terminal count.
module mac_row_seq_beat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic         below_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign below_o = (cnt_q < term_i);
  assign last_o  = ((cnt_q + W'(1)) == term_i);

endmodule

// File: rtl/mac_row_seq.sv
// Sequencer for one MAC row: loads COL kernel beats, streams num_act
// activation beats, then waits for num_act row outputs before finishing.
module mac_row_seq
  import mac_row_seq_pkg::*;
#(
  parameter int BW        = 4,
  parameter int INDEX_SEL = 2,
  parameter int COL       = 8,
  parameter int CNT_BW    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_BW-1:0] num_act,
  output logic              busy,
  output logic              done,
  output logic [CNT_BW-1:0] out_cnt,
  output state_e            dbg_state,
  mac_row_seq_if.master     bus
);

  localparam int DW = BW * INDEX_SEL;

  state_e            state_q, state_d;
  logic [CNT_BW-1:0] num_act_q;
  logic [CNT_BW-1:0] out_cnt_q;
  logic [DW-1:0]     row_in_q;
  logic [1:0]        row_inst_q;

  logic job_start;
  logic w_hs, a_hs;
  logic k_below, k_last;
  logic a_below, a_last;
  logic counting;
  logic w_ready, a_ready;
  logic unused_row_valid;

  assign job_start = (state_q == ST_IDLE) && start;
  assign w_hs      = bus.w_valid && w_ready;
  assign a_hs      = bus.a_valid && a_ready;
  assign counting  = (state_q == ST_EXEC) || (state_q == ST_DRAIN);

  // Only the last column's valid marks a finished output.
  assign unused_row_valid = ^bus.row_valid[COL-2:0];

  mac_row_seq_beat_counter #(.W(CNT_BW)) u_kernel_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (job_start),
    .inc_i   (w_hs),
    .term_i  (CNT_BW'(COL)),
    .below_o (k_below),
    .last_o  (k_last)
  );

  mac_row_seq_beat_counter #(.W(CNT_BW)) u_act_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (job_start),
    .inc_i   (a_hs),
    .term_i  (num_act_q),
    .below_o (a_below),
    .last_o  (a_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  if (w_hs && k_last) state_d = (num_act_q == '0) ? ST_DRAIN : ST_EXEC;
      ST_EXEC:  if (a_hs && a_last) state_d = ST_DRAIN;
      ST_DRAIN: if (out_cnt_q == num_act_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    w_ready = (state_q == ST_LOAD) && k_below;
    a_ready = (state_q == ST_EXEC) && a_below;
  end

  // Row-side outputs are registered: the accepted word reaches the row one
  // cycle after its handshake, and a cycle without a handshake is a NOP
  // bubble that keeps the last data word on the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_act_q  <= '0;
      out_cnt_q  <= '0;
      row_in_q   <= '0;
      row_inst_q <= INST_NOP;
    end else begin
      row_inst_q <= INST_NOP;
      if (job_start) begin
        num_act_q <= num_act;
        out_cnt_q <= '0;
      end else if (counting && bus.row_valid[COL-1] && (out_cnt_q < num_act_q)) begin
        out_cnt_q <= out_cnt_q + CNT_BW'(1);
      end
      if (w_hs) begin
        row_in_q   <= bus.w_data;
        row_inst_q <= INST_LOAD;
      end else if (a_hs) begin
        row_in_q   <= bus.a_data;
        row_inst_q <= INST_EXEC;
      end
    end
  end

  assign bus.w_ready    = w_ready;
  assign bus.a_ready    = a_ready;
  assign bus.row_in_w   = row_in_q;
  assign bus.row_inst_w = row_inst_q;
  assign out_cnt        = out_cnt_q;
  assign dbg_state      = state_q;

endmodule
